// File: rtl/harris_pkg.sv
// Shared types and constants for the Harris corner pipeline.
// window_buffer builds windows of this type and the gradient stage consumes them.
//   PIX_W   : pixel width in bits
//   WIN_SZ  : edge length of the square window sent to the gradient stage
//   GRAD_SZ : edge length of the Gx/Gy tile computed from one window
//   pix_t   : one pixel
//   window_t: WIN_SZ x WIN_SZ pixels, where element [i][j] is row i, column j
package harris_pkg;

    localparam int PIX_W   = 8;
    localparam int WIN_SZ  = 6;
    localparam int GRAD_SZ = 4;

    typedef logic [PIX_W-1:0] pix_t;
    typedef pix_t [0:WIN_SZ-1][0:WIN_SZ-1] window_t;

endpackage

// File: rtl/window_buffer_line_ram.sv
// Storage for one image line: one memory location per column.
// Reads are asynchronous and writes are synchronous.
// During a write the old contents are still visible on o_rdata, so a cascade of
// these RAMs can forward each line into the next RAM.
//   i_clk   : clock
//   i_we    : write enable
//   i_addr  : column address, used for both read and write
//   i_wdata : pixel to write
//   o_rdata : pixel currently stored at i_addr
// Contents are not reset. The control logic never emits a window built from
// locations that have not been written in the current frame.
module line_ram
    import harris_pkg::*;
#(
    parameter int DEPTH = 64,
    parameter int AW    = 6
) (
    input  logic          i_clk,
    input  logic          i_we,
    input  logic [AW-1:0] i_addr,
    input  pix_t          i_wdata,
    output pix_t          o_rdata
);

    pix_t r_mem [0:DEPTH-1];

    // Synchronous write port.
    always_ff @(posedge i_clk) begin
        if (i_we) begin
            r_mem[i_addr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_addr];

endmodule

// File: rtl/window_buffer.sv
// Converts a raster-order pixel stream into a sliding 6x6 window.
// The output feeds the Sobel gradient stage.
//   clk        : clock
//   rst_n      : asynchronous active-low reset
//   pix_in     : input pixel, raster order
//   pix_valid  : pix_in is valid
//   pix_sof    : pix_in is pixel (0,0) of a new frame
//   pix_ready  : the block accepts pix_in this cycle
//   window     : window[i][j] = pixel(row-5+i, col-5+j)
//   win_valid  : window is valid
//   win_ready  : downstream accepts the window
//   win_row    : image row of window[0][0]
//   win_col    : image column of window[0][0]
//   frame_done : one-cycle pulse after the last pixel of a frame is accepted
// Structure:
//   - Five line RAMs hold the previous five lines. Line buffer k holds the line
//     that is k+1 lines older than the current one.
//   - A 6x6 shift array receives one new column per accepted pixel.
//   - The output register holds one window (the output is one entry deep).
module window_buffer
    import harris_pkg::*;
#(
    parameter int IMG_W = 64,
    parameter int IMG_H = 64
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  pix_t                      pix_in,
    input  logic                      pix_valid,
    input  logic                      pix_sof,
    output logic                      pix_ready,
    output window_t                   window,
    output logic                      win_valid,
    input  logic                      win_ready,
    output logic [$clog2(IMG_H)-1:0]  win_row,
    output logic [$clog2(IMG_W)-1:0]  win_col,
    output logic                      frame_done
);

    localparam int CW  = $clog2(IMG_W);
    localparam int RW  = $clog2(IMG_H);
    localparam int NLB = WIN_SZ - 1;

    localparam logic [CW-1:0] COL_LAST  = CW'(IMG_W - 1);
    localparam logic [RW-1:0] ROW_LAST  = RW'(IMG_H - 1);
    localparam logic [CW-1:0] COL_FIRST = CW'(WIN_SZ - 1);
    localparam logic [RW-1:0] ROW_FIRST = RW'(WIN_SZ - 1);

    logic [CW-1:0] r_col;
    logic [RW-1:0] r_row;
    logic          r_win_valid;
    logic          r_frame_done;
    logic [RW-1:0] r_win_row;
    logic [CW-1:0] r_win_col;
    window_t       r_shift;
    window_t       r_window;

    logic          w_accept;
    logic          w_qualify;
    logic          w_last_pix;
    logic [CW-1:0] w_eff_col;
    logic [RW-1:0] w_eff_row;
    logic [CW-1:0] w_col_nxt;
    logic [RW-1:0] w_row_nxt;
    window_t       w_shift_nxt;
    pix_t [NLB-1:0] w_lb_rd;
    pix_t [NLB-1:0] w_lb_wd;

    // The output register is one entry deep. Stall input whenever it holds an
    // unaccepted window, so that a new window never overwrites a pending one.
    assign pix_ready = !(r_win_valid && !win_ready);
    assign w_accept  = pix_valid && pix_ready;

    // Position of the incoming pixel. pix_sof overrides the counters.
    always_comb begin
        w_eff_col = r_col;
        w_eff_row = r_row;
        if (pix_sof) begin
            w_eff_col = {CW{1'b0}};
            w_eff_row = {RW{1'b0}};
        end else begin
            w_eff_col = r_col;
            w_eff_row = r_row;
        end
    end

    assign w_last_pix = (w_eff_col == COL_LAST) && (w_eff_row == ROW_LAST);

    // The window is complete once five earlier lines of this frame are stored
    // and at least six columns of the current line have been shifted in.
    assign w_qualify = w_accept && (w_eff_row >= ROW_FIRST) && (w_eff_col >= COL_FIRST);

    // Counter values that follow the accepted pixel.
    always_comb begin
        w_col_nxt = w_eff_col;
        w_row_nxt = w_eff_row;
        if (w_eff_col == COL_LAST) begin
            w_col_nxt = {CW{1'b0}};
            if (w_eff_row == ROW_LAST) begin
                w_row_nxt = {RW{1'b0}};
            end else begin
                w_row_nxt = w_eff_row + RW'(1'b1);
            end
        end else begin
            w_col_nxt = w_eff_col + CW'(1'b1);
            w_row_nxt = w_eff_row;
        end
    end

    // Line cascade: the new pixel goes into lb0, and each lbK passes its old
    // value at this column down to lbK+1.
    always_comb begin
        w_lb_wd = {NLB{8'h00}};
        w_lb_wd[0] = pix_in;
        for (int k = 1; k < NLB; k++) begin
            w_lb_wd[k] = w_lb_rd[k-1];
        end
    end

    for (genvar k = 0; k < NLB; k++) begin : g_lb
        line_ram #(
            .DEPTH (IMG_W),
            .AW    (CW)
        ) u_line_ram (
            .i_clk   (clk),
            .i_we    (w_accept),
            .i_addr  (w_eff_col),
            .i_wdata (w_lb_wd[k]),
            .o_rdata (w_lb_rd[k])
        );
    end

    // Shift the columns left by one. The new rightmost column holds the oldest
    // line in row 0 and pix_in in the bottom row.
    always_comb begin
        w_shift_nxt = r_shift;
        for (int i = 0; i < WIN_SZ; i++) begin
            for (int j = 0; j < WIN_SZ - 1; j++) begin
                w_shift_nxt[i][j] = r_shift[i][j+1];
            end
        end
        for (int i = 0; i < NLB; i++) begin
            w_shift_nxt[i][WIN_SZ-1] = w_lb_rd[NLB-1-i];
        end
        w_shift_nxt[WIN_SZ-1][WIN_SZ-1] = pix_in;
    end

    // Pixel position counters and the shift array advance on every accepted pixel.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_col   <= {CW{1'b0}};
            r_row   <= {RW{1'b0}};
            r_shift <= '0;
        end else if (w_accept) begin
            r_col   <= w_col_nxt;
            r_row   <= w_row_nxt;
            r_shift <= w_shift_nxt;
        end else begin
            r_col   <= r_col;
            r_row   <= r_row;
            r_shift <= r_shift;
        end
    end

    // Output register. It loads on a qualifying accept and clears on a
    // handshake that has no replacement window.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_win_valid <= 1'b0;
            r_window    <= '0;
            r_win_row   <= {RW{1'b0}};
            r_win_col   <= {CW{1'b0}};
        end else if (w_qualify) begin
            r_win_valid <= 1'b1;
            r_window    <= w_shift_nxt;
            r_win_row   <= w_eff_row - ROW_FIRST;
            r_win_col   <= w_eff_col - COL_FIRST;
        end else if (win_ready) begin
            r_win_valid <= 1'b0;
        end else begin
            r_win_valid <= r_win_valid;
        end
    end

    // End-of-frame pulse, one cycle after the last pixel is accepted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_frame_done <= 1'b0;
        end else begin
            r_frame_done <= w_accept && w_last_pix;
        end
    end

    assign window     = r_window;
    assign win_valid  = r_win_valid;
    assign win_row    = r_win_row;
    assign win_col    = r_win_col;
    assign frame_done = r_frame_done;

endmodule

// File: tb/tb_window_buffer.sv
// Directed bench for window_buffer with an 8x8 image.
module tb_window_buffer;
    import harris_pkg::*;

    localparam int W = 8;
    localparam int H = 8;

    logic    clk = 1'b0;
    logic    rst_n = 1'b0;
    pix_t    pix_in = 8'h00;
    logic    pix_valid = 1'b0;
    logic    pix_sof = 1'b0;
    logic    pix_ready;
    window_t window;
    logic    win_valid;
    logic    win_ready = 1'b1;
    logic [2:0] win_row;
    logic [2:0] win_col;
    logic    frame_done;

    int checks = 0;
    int errors = 0;
    int win_cnt = 0;
    int fd_cnt = 0;

    window_buffer #(.IMG_W(W), .IMG_H(H)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .pix_in     (pix_in),
        .pix_valid  (pix_valid),
        .pix_sof    (pix_sof),
        .pix_ready  (pix_ready),
        .window     (window),
        .win_valid  (win_valid),
        .win_ready  (win_ready),
        .win_row    (win_row),
        .win_col    (win_col),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_w(input string tag, input window_t obs, input window_t exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic pix_t pix_of(input int r, input int c, input int pat);
        if (pat == 0) return pix_t'(r * W + c);
        return (((r + c) % 3) == 0) ? 8'h05 : 8'hFD;
    endfunction

    function automatic window_t exp_win(input int wr, input int wc, input int pat);
        window_t w;
        for (int i = 0; i < WIN_SZ; i++)
            for (int j = 0; j < WIN_SZ; j++)
                w[i][j] = pix_of(wr + i, wc + j, pat);
        return w;
    endfunction

    // Present one pixel and wait (bounded) until it is accepted; return #1 after that edge.
    task automatic send(input pix_t p, input logic sof);
        int budget;
        @(negedge clk);
        pix_in = p;
        pix_valid = 1'b1;
        pix_sof = sof;
        budget = 0;
        while (!pix_ready && budget < 20) begin
            @(negedge clk);
            budget++;
        end
        chk("accept_wait", 32'(pix_ready), 32'd1);
        @(posedge clk);
        #1;
        pix_valid = 1'b0;
        pix_sof = 1'b0;
    endtask

    task automatic check_px(input int r, input int c, input int pat);
        logic q;
        q = (r >= 5) && (c >= 5);
        chk("win_valid", 32'(win_valid), 32'(q));
        if (q) begin
            win_cnt++;
            chk("win_row", 32'(win_row), 32'(r - 5));
            chk("win_col", 32'(win_col), 32'(c - 5));
            chk_w("window", window, exp_win(r - 5, c - 5, pat));
        end
        chk("frame_done", 32'(frame_done), 32'((r == H - 1) && (c == W - 1)));
        if (frame_done) fd_cnt++;
    endtask

    task automatic run_frame(input int pat, input logic stall, input logic sof_first, input int npix);
        int r;
        int c;
        for (int k = 0; k < npix; k++) begin
            r = k / W;
            c = k % W;
            send(pix_of(r, c, pat), sof_first && (k == 0));
            check_px(r, c, pat);
            if (stall && r == 5 && c == 5) begin
                win_ready = 1'b0;
                pix_in = pix_of(5, 6, pat);
                pix_valid = 1'b1;
                repeat (3) begin
                    @(posedge clk);
                    #1;
                    chk("stall_valid", 32'(win_valid), 32'd1);
                    chk("stall_pix_ready", 32'(pix_ready), 32'd0);
                    chk("stall_row", 32'(win_row), 32'd0);
                    chk_w("stall_window", window, exp_win(0, 0, pat));
                end
                pix_valid = 1'b0;
                win_ready = 1'b1;
            end
        end
    endtask

    initial begin
        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_win_valid", 32'(win_valid), 32'd0);
        chk("rst_frame_done", 32'(frame_done), 32'd0);
        chk("rst_win_row", 32'(win_row), 32'd0);
        chk("rst_win_col", 32'(win_col), 32'd0);
        chk("rst_pix_ready", 32'(pix_ready), 32'd1);
        chk_w("rst_window", window, '0);
        @(negedge clk);
        rst_n = 1'b1;

        // Frame A: ramp pattern, no backpressure
        win_cnt = 0; fd_cnt = 0;
        run_frame(0, 1'b0, 1'b0, 64);
        chk("a_win_count", 32'(win_cnt), 32'd9);
        chk("a_fd_count", 32'(fd_cnt), 32'd1);

        // Frame B: back-to-back, stale RAM, stall at the first window
        win_cnt = 0; fd_cnt = 0;
        run_frame(0, 1'b1, 1'b0, 64);
        chk("b_win_count", 32'(win_cnt), 32'd9);
        chk("b_fd_count", 32'(fd_cnt), 32'd1);

        // Frame C: checker pattern
        win_cnt = 0; fd_cnt = 0;
        run_frame(1, 1'b0, 1'b0, 64);
        chk("c_win_count", 32'(win_cnt), 32'd9);
        chk("c_fd_count", 32'(fd_cnt), 32'd1);

        // 20 pixels of a partial frame, then a frame restarted with pix_sof
        win_cnt = 0; fd_cnt = 0;
        run_frame(1, 1'b0, 1'b0, 20);
        run_frame(0, 1'b0, 1'b1, 64);
        chk("sof_win_count", 32'(win_cnt), 32'd9);
        chk("sof_fd_count", 32'(fd_cnt), 32'd1);

        // Reset while a window is pending, then a full frame
        run_frame(0, 1'b0, 1'b0, 46);
        win_ready = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_win_valid", 32'(win_valid), 32'd0);
        chk("midrst_pix_ready", 32'(pix_ready), 32'd1);
        chk("midrst_win_col", 32'(win_col), 32'd0);
        chk_w("midrst_window", window, '0);
        @(negedge clk);
        rst_n = 1'b1;
        win_ready = 1'b1;
        win_cnt = 0; fd_cnt = 0;
        run_frame(0, 1'b0, 1'b0, 64);
        chk("rst_win_count", 32'(win_cnt), 32'd9);
        chk("rst_fd_count", 32'(fd_cnt), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
